// File: rtl/memory_access_unit.sv
// memory_access_unit: RV32I memory stage; runs loads/stores over a req/ack bus, stalls upstream while busy, registers the W bundle.
//  clk, rst (async active-low)
//  M bundle in : RegWriteM, MemWriteM, ResultSrcM, Funct3M, RD_M, PCPlus4M, ALU_ResultM, WriteDataM
//  StallM      : hold upstream pipeline registers
//  bus         : bus_req/bus_we/bus_addr/bus_be/bus_wdata out, bus_ack/bus_rdata in
//  W bundle out: RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW, BusErrW
module memory_access_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW,
  output logic        BusErrW
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        mem_op, misalign, start, timeout, done;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sign;
  assign mem_op   = MemWriteM | ResultSrcM;
  assign misalign = mem_op && ((Funct3M[1:0] == 2'b01 && ALU_ResultM[0]) ||
                               (Funct3M[1:0] == 2'b10 && ALU_ResultM[1:0] != 2'b00));
  assign start    = state == IDLE && mem_op && !misalign;
  // the abort cycle itself drops bus_req, so an ack arriving then is not taken
  assign timeout  = state == BUSY && cnt == 8'(MAX_WAIT);
  assign done     = state == BUSY && bus_ack && !timeout;
  assign bus_req  = state == BUSY && !timeout;
  // gated by rst so every output reads 0 while reset is held
  assign StallM   = rst && (start || (bus_req && !bus_ack));
  always_comb begin
    be_n    = !MemWriteM ? 4'b1111 :
              Funct3M[1:0] == 2'b00 ? 4'b0001 << ALU_ResultM[1:0] :
              Funct3M[1:0] == 2'b01 ? (ALU_ResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = !MemWriteM ? 32'd0 :
              Funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
              Funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
    ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_sign = !f3_q[2];
    ld_data = f3_q[1:0] == 2'b00 ? {{24{ld_sign & ld_byte[7]}}, ld_byte} :
              f3_q[1:0] == 2'b01 ? {{16{ld_sign & ld_half[15]}}, ld_half} : bus_rdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else if (state == IDLE) begin
      if (start) begin
        state     <= BUSY;
        cnt       <= 8'd0;
        f3_q      <= Funct3M;
        off_q     <= ALU_ResultM[1:0];
        bus_we    <= MemWriteM;
        bus_addr  <= {ALU_ResultM[31:2], 2'b00};
        bus_be    <= be_n;
        bus_wdata <= wdata_n;
      end
    end else begin
      if (bus_ack || timeout) state <= IDLE;
      cnt <= (cnt == 8'(MAX_WAIT)) ? cnt : cnt + 8'd1;
    end
  end
  // a stalled cycle loads an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= 5'd0;
      PCPlus4W    <= 32'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
      MisalignW   <= 1'b0;
      BusErrW     <= 1'b0;
    end else begin
      RegWriteW   <= !StallM && RegWriteM && !misalign && !timeout;
      ResultSrcW  <= !StallM && ResultSrcM;
      RD_W        <= StallM ? 5'd0 : RD_M;
      PCPlus4W    <= StallM ? 32'd0 : PCPlus4M;
      ALU_ResultW <= StallM ? 32'd0 : ALU_ResultM;
      ReadDataW   <= (done && !bus_we) ? ld_data : 32'd0;
      MisalignW   <= !StallM && state == IDLE && misalign;
      BusErrW     <= timeout;
    end
  end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed bench for memory_access_unit with MAX_WAIT=4.
module tb_memory_access_unit;
  logic        clk, rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        StallM, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        RegWriteW, ResultSrcW, MisalignW, BusErrW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  int checks = 0, failures = 0;
  int st, reqs;
  logic [31:0] a, wd, rdw0;
  logic [3:0]  be;
  logic        we, req, rwb, fin, ended;
  memory_access_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .MisalignW(MisalignW), .BusErrW(BusErrW)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_m(input logic rw, mw, rs, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc, addr, d);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3; RD_M = rd;
    PCPlus4M = pc; ALU_ResultM = addr; WriteDataM = d;
  endtask
  task automatic clr_m();
    set_m(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask
  // entered just after a rising edge with the op already on the M inputs; ack is raised in cycle ack_at
  task automatic do_access(input int ack_at, input logic [31:0] rdata, output int stalls,
                           output logic [31:0] addr_o, output logic [3:0] be_o,
                           output logic [31:0] wd_o, output logic we_o, req_o, rw_before,
                           output logic [31:0] w0);
    stalls = 0; addr_o = 0; be_o = 0; wd_o = 0; we_o = 0; req_o = 0; rw_before = 1; w0 = 0;
    for (int c = 0; c <= ack_at; c++) begin
      if (c == ack_at) begin bus_ack = 1'b1; bus_rdata = rdata; end
      @(negedge clk);
      if (StallM) stalls++;
      if (c == 0) w0 = ReadDataW;
      if (c == 1) begin addr_o = bus_addr; be_o = bus_be; wd_o = bus_wdata; we_o = bus_we; req_o = bus_req; end
      if (c == ack_at) rw_before = RegWriteW;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    clr_m();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b0; clr_m(); bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", bus_req, 0); chk("rst_stall", StallM, 0);
    chk("rst_rw", RegWriteW, 0); chk("rst_be", bus_be, 0);
    @(posedge clk); #1 rst = 1'b1;
    set_m(1, 0, 0, 3'b000, 5'd5, 32'h104, 32'h1234, 32'd0);
    @(negedge clk); chk("alu_stall", StallM, 0); chk("alu_req", bus_req, 0);
    @(posedge clk); #1 clr_m();
    @(negedge clk);
    chk("alu_rw", RegWriteW, 1); chk("alu_rd", RD_W, 5);
    chk("alu_res", ALU_ResultW, 32'h1234); chk("alu_pc", PCPlus4W, 32'h104);
    @(posedge clk); #1;
    set_m(1, 0, 1, 3'b000, 5'd7, 32'h200, 32'h1003, 32'd0);
    do_access(3, 32'h80FF_0000, st, a, be, wd, we, req, rwb, rdw0);
    chk("lb_stalls", st, 3); chk("lb_addr", a, 32'h1000); chk("lb_we", we, 0);
    chk("lb_be", be, 4'hF); chk("lb_req", req, 1); chk("lb_bubble", rwb, 0);
    @(negedge clk);
    chk("lb_data", ReadDataW, 32'hFFFF_FF80); chk("lb_rw", RegWriteW, 1);
    chk("lb_rd", RD_W, 7); chk("lb_src", ResultSrcW, 1);
    @(posedge clk); #1;
    set_m(1, 0, 1, 3'b101, 5'd8, 32'h300, 32'h2002, 32'd0);
    do_access(1, 32'hBEEF_1234, st, a, be, wd, we, req, rwb, rdw0);
    chk("lhu_stalls", st, 1); chk("lhu_addr", a, 32'h2000); chk("lhu_bubble", rwb, 0);
    @(negedge clk); chk("lhu_data", ReadDataW, 32'h0000_BEEF); chk("lhu_rw", RegWriteW, 1);
    @(posedge clk); #1;
    set_m(1, 0, 1, 3'b001, 5'd9, 32'h400, 32'h3000, 32'd0);
    do_access(2, 32'h1234_8001, st, a, be, wd, we, req, rwb, rdw0);
    chk("lh_stalls", st, 2);
    @(negedge clk); chk("lh_data", ReadDataW, 32'hFFFF_8001);
    @(posedge clk); #1;
    set_m(0, 1, 0, 3'b000, 5'd0, 32'h500, 32'h0001, 32'h0000_00A5);
    do_access(1, 32'hFFFF_FFFF, st, a, be, wd, we, req, rwb, rdw0);
    chk("sb_be", be, 4'b0010); chk("sb_wdata", wd, 32'hA5A5_A5A5); chk("sb_we", we, 1);
    chk("sb_addr", a, 32'h0); chk("sb_req", req, 1);
    @(negedge clk); chk("sb_rdata", ReadDataW, 0); chk("sb_rw", RegWriteW, 0);
    @(posedge clk); #1;
    set_m(0, 1, 0, 3'b001, 5'd0, 32'h504, 32'h0002, 32'h1234_ABCD);
    do_access(1, 32'd0, st, a, be, wd, we, req, rwb, rdw0);
    chk("sh_be", be, 4'b1100); chk("sh_wdata", wd, 32'hABCD_ABCD);
    set_m(0, 1, 0, 3'b010, 5'd0, 32'h508, 32'h0008, 32'hDEAD_BEEF);
    do_access(1, 32'd0, st, a, be, wd, we, req, rwb, rdw0);
    chk("sw_be", be, 4'b1111); chk("sw_wdata", wd, 32'hDEAD_BEEF); chk("sw_addr", a, 32'h8);
    set_m(1, 0, 1, 3'b010, 5'd9, 32'h600, 32'h0006, 32'd0);
    @(negedge clk); chk("mis_stall", StallM, 0); chk("mis_req", bus_req, 0);
    @(posedge clk); #1 clr_m();
    @(negedge clk);
    chk("mis_flag", MisalignW, 1); chk("mis_rw", RegWriteW, 0); chk("mis_req2", bus_req, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("mis_pulse", MisalignW, 0);
    @(posedge clk); #1;
    set_m(1, 0, 1, 3'b010, 5'd10, 32'h700, 32'h0040, 32'd0);
    do_access(1, 32'h1111_1111, st, a, be, wd, we, req, rwb, rdw0);
    set_m(1, 0, 1, 3'b100, 5'd11, 32'h704, 32'h0045, 32'd0);
    do_access(1, 32'h0000_9C00, st, a, be, wd, we, req, rwb, rdw0);
    chk("b2b_first", rdw0, 32'h1111_1111); chk("b2b_stalls", st, 1); chk("b2b_addr", a, 32'h44);
    @(negedge clk); chk("b2b_data", ReadDataW, 32'h0000_009C); chk("b2b_rd", RD_W, 11);
    @(posedge clk); #1;
    set_m(1, 0, 1, 3'b010, 5'd12, 32'h800, 32'h0010, 32'd0);
    reqs = 0; ended = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_req) reqs++;
      fin = !StallM;
      @(posedge clk); #1;
      if (fin) begin ended = 1'b1; break; end
    end
    clr_m();
    chk("tmo_ended", ended, 1); chk("tmo_req_cycles", reqs, 4);
    @(negedge clk);
    chk("tmo_err", BusErrW, 1); chk("tmo_rw", RegWriteW, 0); chk("tmo_req", bus_req, 0);
    @(posedge clk); #1 bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk); chk("tmo_pulse", BusErrW, 0); chk("idle_ack_req", bus_req, 0);
    chk("idle_ack_stall", StallM, 0);
    @(posedge clk); #1 bus_ack = 1'b0;
    @(negedge clk); chk("idle_ack_data", ReadDataW, 0);
    @(posedge clk); #1;
    set_m(1, 0, 1, 3'b010, 5'd13, 32'h900, 32'h0020, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstb_req_before", bus_req, 1);
    rst = 1'b0;
    #1;
    chk("rstb_req", bus_req, 0); chk("rstb_stall", StallM, 0);
    chk("rstb_addr", bus_addr, 0); chk("rstb_rw", RegWriteW, 0);
    chk("rstb_err", BusErrW, 0); chk("rstb_data", ReadDataW, 0);
    clr_m(); bus_ack = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("late_ack_req", bus_req, 0); chk("late_ack_stall", StallM, 0);
    @(posedge clk); #1 bus_ack = 1'b0;
    @(negedge clk); chk("late_ack_rw", RegWriteW, 0); chk("late_ack_data", ReadDataW, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
